// File: rtl/pulse_burst_tx_pkg.sv
// Shared definitions for the two-channel pulse burst transmitter:
// channel FSM states, input pin indices, pulse shape and burst length decode.
package pulse_burst_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } chan_state_e;

    // Bit positions inside the packed io_in bus.
    localparam int PIN_CLK       = 0;
    localparam int PIN_RST_N     = 1;
    localparam int PIN_LOAD      = 2;
    localparam int PIN_CHAN_SEL  = 3;
    localparam int PIN_COUNT_LSB = 4;
    localparam int PIN_COUNT_MSB = 7;

    // Number of cycles each pulse stays high; the low gap is always one cycle.
    localparam int PULSE_WIDTH  = 1;
    localparam int PULSE_HOLD_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;

    // A requested count of zero stands for a full 16-pulse burst.
    function automatic logic [4:0] burst_len(input logic [3:0] count);
        return (count == 4'd0) ? 5'd16 : {1'b0, count};
    endfunction

endpackage

// File: rtl/pulse_burst_tx_channel.sv
// One independent pulse channel: IDLE/HIGH/LOW FSM, remaining-pulse counter
// and a free-running 4-bit mirror of the number of pulses emitted.
// Handshake: start_i is a single-cycle request; it is honoured only when the
// channel is IDLE on that edge and silently dropped otherwise (no queueing).
module pulse_channel
    import pulse_burst_tx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [3:0] count_i,
    output logic       pulse_o,
    output logic       busy_o,
    output logic [3:0] mirror_o
);

    chan_state_e             state_q;
    logic [4:0]              remaining_q;
    logic [PULSE_HOLD_W-1:0] hold_q;
    logic                    pulse_q;
    logic                    busy_q;
    logic [3:0]              mirror_q;

    // Channel FSM with registered pulse/busy outputs and the mirror counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            remaining_q <= 5'd0;
            hold_q      <= '0;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
            mirror_q    <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q     <= ST_HIGH;
                        remaining_q <= burst_len(count_i);
                        hold_q      <= '0;
                        pulse_q     <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (hold_q == PULSE_HOLD_W'(PULSE_WIDTH - 1)) begin
                        state_q  <= ST_LOW;
                        hold_q   <= '0;
                        pulse_q  <= 1'b0;
                        // Counts the pulse as it completes, like a downstream
                        // ripple counter would.
                        mirror_q <= mirror_q + 4'd1;
                    end else begin
                        hold_q <= hold_q + PULSE_HOLD_W'(1);
                    end
                end
                ST_LOW: begin
                    if (remaining_q > 5'd1) begin
                        remaining_q <= remaining_q - 5'd1;
                        state_q     <= ST_HIGH;
                        pulse_q     <= 1'b1;
                    end else begin
                        remaining_q <= 5'd0;
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_o  = pulse_q;
    assign busy_o   = busy_q;
    assign mirror_o = mirror_q;

endmodule

// File: rtl/pulse_burst_tx.sv
// Two-channel pulse burst transmitter on a packed 8-bit pin bus.
// The asynchronous load request is synchronised and edge-detected here; each
// rising edge starts a burst on the channel chosen by chan_sel.
module pulse_burst_tx
    import pulse_burst_tx_pkg::*;
(
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic       clk;
    logic       rst_n;
    logic       load_raw;
    logic       chan_sel;
    logic [3:0] count;

    assign clk      = io_in[PIN_CLK];
    assign rst_n    = io_in[PIN_RST_N];
    assign load_raw = io_in[PIN_LOAD];
    assign chan_sel = io_in[PIN_CHAN_SEL];
    assign count    = io_in[PIN_COUNT_MSB:PIN_COUNT_LSB];

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;
    logic load_evt;

    // Two-flop synchroniser for load plus a third flop for rising-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= load_raw;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign load_evt = sync2_q & ~sync3_q;

    logic       pulse_a;
    logic       pulse_b;
    logic       busy_a;
    logic       busy_b;
    logic [3:0] mirror_a;
    logic [3:0] mirror_b;

    pulse_channel u_chan_a (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (load_evt & ~chan_sel),
        .count_i  (count),
        .pulse_o  (pulse_a),
        .busy_o   (busy_a),
        .mirror_o (mirror_a)
    );

    pulse_channel u_chan_b (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (load_evt & chan_sel),
        .count_i  (count),
        .pulse_o  (pulse_b),
        .busy_o   (busy_b),
        .mirror_o (mirror_b)
    );

    // Mirror display follows chan_sel combinationally; the rest is registered.
    assign io_out = {(chan_sel ? mirror_b : mirror_a), busy_b, busy_a, pulse_b, pulse_a};

endmodule
